// File: rtl/pov_pkg.sv
// ---------------------------------------------------------------------------
// pov_pkg : shared types and bundle layout for the point-of-view write path
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pov_pkg;

    localparam int VEC_W_DEF = 16;
    localparam int N_FIELDS  = 6;

    // Field order inside a bundle, MSB first
    localparam int F_PLAYER_X = 0;
    localparam int F_PLAYER_Y = 1;
    localparam int F_FACING_X = 2;
    localparam int F_FACING_Y = 3;
    localparam int F_VPLANE_X = 4;
    localparam int F_VPLANE_Y = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        COMMIT  = 2'd2
    } state_e;

    typedef enum logic {
        HOST   = 1'b0,
        PRESET = 1'b1
    } req_id_e;

    function automatic int field_lsb(input int field, input int w);
        return (N_FIELDS - 1 - field) * w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2 : combinational 2-way round-robin arbiter (history held by parent)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arb2
    import pov_pkg::*;
(
    input  logic [1:0] req_i,
    input  req_id_e    last_grant_i,
    output logic [1:0] grant_o,
    output req_id_e    grant_id_o
);

    always_comb begin
        grant_id_o = HOST;
        case (req_i)
            2'b10:   grant_id_o = PRESET;
            // Tie goes to whoever was not served last
            2'b11:   grant_id_o = (last_grant_i == HOST) ? PRESET : HOST;
            default: grant_id_o = HOST;
        endcase

        grant_o = 2'b00;
        if (req_i != 2'b00) begin
            grant_o = (grant_id_o == HOST) ? 2'b01 : 2'b10;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pov_write_sched.sv
// ---------------------------------------------------------------------------
// pov_write_sched : arbitrates host/preset view writes, commits in vblank
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pov_write_sched
    import pov_pkg::*;
#(
    parameter int VEC_W = VEC_W_DEF,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vblank,
    input  logic                  host_req,
    input  logic [6*VEC_W-1:0]    host_pos,
    output logic                  host_ack,
    input  logic                  preset_req,
    input  logic [6*VEC_W-1:0]    preset_pos,
    output logic                  preset_ack,
    output logic                  write_new_position,
    output logic [VEC_W-1:0]      new_playerX,
    output logic [VEC_W-1:0]      new_playerY,
    output logic [VEC_W-1:0]      new_facingX,
    output logic [VEC_W-1:0]      new_facingY,
    output logic [VEC_W-1:0]      new_vplaneX,
    output logic [VEC_W-1:0]      new_vplaneY,
    output logic                  busy,
    output logic [CNT_W-1:0]      commit_count
);

    localparam int BUNDLE_W = N_FIELDS * VEC_W;

    state_e                state_q, state_d;
    req_id_e               last_grant_q, last_grant_d;
    logic [BUNDLE_W-1:0]   pend_q, pend_d;
    logic [BUNDLE_W-1:0]   newpos_q, newpos_d;
    logic                  host_ack_q, host_ack_d;
    logic                  preset_ack_q, preset_ack_d;
    logic                  wnp_q, wnp_d;
    logic                  done_q, done_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [1:0]            grant;
    req_id_e               grant_id;

    rr_arb2 u_arb (
        .req_i        ({preset_req, host_req}),
        .last_grant_i (last_grant_q),
        .grant_o      (grant),
        .grant_id_o   (grant_id)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        pend_d       = pend_q;
        newpos_d     = newpos_q;
        host_ack_d   = 1'b0;
        preset_ack_d = 1'b0;
        wnp_d        = 1'b0;
        cnt_d        = cnt_q;
        done_d       = vblank ? done_q : 1'b0;

        case (state_q)
            IDLE: begin
                if (grant != 2'b00) begin
                    state_d      = PENDING;
                    last_grant_d = grant_id;
                    pend_d       = (grant_id == HOST) ? host_pos : preset_pos;
                    host_ack_d   = grant[0];
                    preset_ack_d = grant[1];
                end
            end
            PENDING: begin
                // Strobe and data are registered on entry so they appear together
                if (vblank && !done_q) begin
                    state_d  = COMMIT;
                    newpos_d = pend_q;
                    wnp_d    = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    done_d   = 1'b1;
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= PRESET;
            pend_q       <= '0;
            newpos_q     <= '0;
            host_ack_q   <= 1'b0;
            preset_ack_q <= 1'b0;
            wnp_q        <= 1'b0;
            done_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            pend_q       <= pend_d;
            newpos_q     <= newpos_d;
            host_ack_q   <= host_ack_d;
            preset_ack_q <= preset_ack_d;
            wnp_q        <= wnp_d;
            done_q       <= done_d;
            cnt_q        <= cnt_d;
        end
    end

    assign host_ack           = host_ack_q;
    assign preset_ack         = preset_ack_q;
    assign write_new_position = wnp_q;
    assign busy               = (state_q != IDLE);
    assign commit_count       = cnt_q;

    assign new_playerX = newpos_q[field_lsb(F_PLAYER_X, VEC_W) +: VEC_W];
    assign new_playerY = newpos_q[field_lsb(F_PLAYER_Y, VEC_W) +: VEC_W];
    assign new_facingX = newpos_q[field_lsb(F_FACING_X, VEC_W) +: VEC_W];
    assign new_facingY = newpos_q[field_lsb(F_FACING_Y, VEC_W) +: VEC_W];
    assign new_vplaneX = newpos_q[field_lsb(F_VPLANE_X, VEC_W) +: VEC_W];
    assign new_vplaneY = newpos_q[field_lsb(F_VPLANE_Y, VEC_W) +: VEC_W];

endmodule

`default_nettype wire

// File: tb/tb_pov_write_sched.sv
// ---------------------------------------------------------------------------
// tb_pov_write_sched : directed, table-driven bench for pov_write_sched
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pov_write_sched;

    localparam int VW = 16;
    localparam int CW = 8;
    localparam int BW = 6 * VW;

    logic          clk = 1'b0;
    logic          reset;
    logic          vblank;
    logic          host_req;
    logic [BW-1:0] host_pos;
    logic          host_ack;
    logic          preset_req;
    logic [BW-1:0] preset_pos;
    logic          preset_ack;
    logic          write_new_position;
    logic [VW-1:0] new_playerX, new_playerY, new_facingX, new_facingY, new_vplaneX, new_vplaneY;
    logic          busy;
    logic [CW-1:0] commit_count;

    pov_write_sched #(.VEC_W(VW), .CNT_W(CW)) dut (
        .clk                (clk),
        .reset              (reset),
        .vblank             (vblank),
        .host_req           (host_req),
        .host_pos           (host_pos),
        .host_ack           (host_ack),
        .preset_req         (preset_req),
        .preset_pos         (preset_pos),
        .preset_ack         (preset_ack),
        .write_new_position (write_new_position),
        .new_playerX        (new_playerX),
        .new_playerY        (new_playerY),
        .new_facingX        (new_facingX),
        .new_facingY        (new_facingY),
        .new_vplaneX        (new_vplaneX),
        .new_vplaneY        (new_vplaneY),
        .busy               (busy),
        .commit_count       (commit_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int strobes  = 0;

    a_strobe_in_vblank: assert property (@(posedge clk) disable iff (reset)
        write_new_position |-> vblank);

    always @(negedge clk) begin
        if (!reset && write_new_position) begin
            strobes++;
            if (!vblank) begin
                n_err++;
                $display("FAIL strobe_outside_vblank: vblank=%0b required 1", vblank);
            end
        end
    end

    typedef struct {
        bit             is_host;
        logic [BW-1:0]  bundle;
        logic [VW-1:0]  px, py, fx, fy, vx, vy;
        logic [CW-1:0]  cnt;
    } vec_t;

    vec_t tbl[4];

    wire [BW-1:0] newpos = {new_playerX, new_playerY, new_facingX,
                            new_facingY, new_vplaneX, new_vplaneY};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        host_req   = 1'b0;
        preset_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_ack(input bit is_host, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (is_host ? host_ack : preset_ack) begin
                ok = 1'b1;
                break;
            end
        end
        chk("ack_within_budget", ok, 1'b1);
    endtask

    initial begin
        logic [BW-1:0] hc;
        int            s0;

        tbl[0] = '{1'b1, 96'h0100_0200_0300_0400_0500_0600,
                   16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600, 8'd1};
        tbl[1] = '{1'b0, 96'h1111_2222_3333_4444_5555_6666,
                   16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 8'd2};
        tbl[2] = '{1'b1, 96'hFFFF_8000_7FFF_0001_0000_ABCD,
                   16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001, 16'h0000, 16'hABCD, 8'd3};
        tbl[3] = '{1'b0, 96'hDEAD_BEEF_CAFE_F00D_1234_5678,
                   16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D, 16'h1234, 16'h5678, 8'd4};

        vblank     = 1'b0;
        host_pos   = '0;
        preset_pos = '0;
        do_reset();

        chk("rst_wnp",    write_new_position, 1'b0);
        chk("rst_busy",   busy, 1'b0);
        chk("rst_acks",   {host_ack, preset_ack}, 2'b00);
        chk("rst_newpos", newpos, '0);
        chk("rst_count",  commit_count, '0);

        // Minimum-latency commit for each table vector
        for (int i = 0; i < 4; i++) begin
            vblank = 1'b0;
            tick();
            vblank = 1'b1;
            if (tbl[i].is_host) begin host_req = 1'b1; host_pos = tbl[i].bundle; end
            else begin preset_req = 1'b1; preset_pos = tbl[i].bundle; end
            tick();
            chk("vec_ack_granted", tbl[i].is_host ? host_ack : preset_ack, 1'b1);
            chk("vec_ack_other",   tbl[i].is_host ? preset_ack : host_ack, 1'b0);
            chk("vec_no_early_wnp", write_new_position, 1'b0);
            tick();
            host_req   = 1'b0;
            preset_req = 1'b0;
            chk("vec_wnp", write_new_position, 1'b1);
            chk("vec_newpos", newpos, {tbl[i].px, tbl[i].py, tbl[i].fx,
                                       tbl[i].fy, tbl[i].vx, tbl[i].vy});
            chk("vec_count", commit_count, tbl[i].cnt);
            tick();
            chk("vec_wnp_one_cycle", write_new_position, 1'b0);
            chk("vec_idle", busy, 1'b0);
        end

        // Request outside blanking waits for the rise
        vblank   = 1'b0;
        host_req = 1'b1;
        host_pos = 96'h0A0A_0B0B_0C0C_0D0D_0E0E_0F0F;
        wait_ack(1'b1, 5);
        tick();
        host_req = 1'b0;
        s0 = strobes;
        repeat (50) tick();
        chk("wait_no_strobe", strobes, s0);
        chk("wait_busy", busy, 1'b1);
        vblank = 1'b1;
        tick();
        chk("wait_wnp_on_rise", write_new_position, 1'b1);
        chk("wait_newpos", newpos, 96'h0A0A_0B0B_0C0C_0D0D_0E0E_0F0F);
        tick();
        tick();
        chk("wait_single_strobe", strobes, s0 + 1);
        chk("wait_count", commit_count, 8'd5);

        // Contention: host wins first tie, then round-robin alternates
        do_reset();
        vblank     = 1'b1;
        host_pos   = 96'hA001_A002_A003_A004_A005_A006;
        preset_pos = 96'hB001_B002_B003_B004_B005_B006;
        host_req   = 1'b1;
        preset_req = 1'b1;
        tick();
        chk("tie1_host_ack",   host_ack, 1'b1);
        chk("tie1_preset_ack", preset_ack, 1'b0);
        tick();
        host_req = 1'b0;
        chk("tie1_wnp", write_new_position, 1'b1);
        chk("tie1_newpos", newpos, 96'hA001_A002_A003_A004_A005_A006);
        tick();
        chk("tie1_idle", busy, 1'b0);
        hc       = 96'hC001_C002_C003_C004_C005_C006;
        host_pos = hc;
        host_req = 1'b1;
        tick();
        chk("tie2_preset_ack", preset_ack, 1'b1);
        chk("tie2_host_ack",   host_ack, 1'b0);
        tick();
        preset_req = 1'b0;
        chk("tie2_held_same_vblank", write_new_position, 1'b0);
        vblank = 1'b0;
        tick();
        tick();
        vblank = 1'b1;
        tick();
        chk("tie2_wnp", write_new_position, 1'b1);
        chk("tie2_newpos", newpos, 96'hB001_B002_B003_B004_B005_B006);
        chk("tie2_count", commit_count, 8'd2);
        tick();
        tick();
        chk("tie3_host_ack", host_ack, 1'b1);
        tick();
        host_req = 1'b0;
        chk("tie3_held", write_new_position, 1'b0);
        vblank = 1'b0;
        tick();
        vblank = 1'b1;
        tick();
        chk("tie3_newpos", newpos, hc);
        chk("tie3_count", commit_count, 8'd3);
        tick();

        // Two requests in one blanking: second waits for the next one
        vblank = 1'b0;
        tick();
        vblank   = 1'b1;
        host_req = 1'b1;
        host_pos = 96'hD001_D002_D003_D004_D005_D006;
        tick();
        chk("b2b_first_ack", host_ack, 1'b1);
        tick();
        host_req = 1'b0;
        chk("b2b_first_count", commit_count, 8'd4);
        tick();
        host_req = 1'b1;
        host_pos = 96'hE001_E002_E003_E004_E005_E006;
        tick();
        chk("b2b_second_ack", host_ack, 1'b1);
        tick();
        host_req = 1'b0;
        s0 = strobes;
        repeat (10) tick();
        chk("b2b_no_strobe", strobes, s0);
        chk("b2b_count_hold", commit_count, 8'd4);
        vblank = 1'b0;
        repeat (3) tick();
        chk("b2b_no_strobe_low", strobes, s0);
        vblank = 1'b1;
        tick();
        chk("b2b_second_wnp", write_new_position, 1'b1);
        chk("b2b_second_newpos", newpos, 96'hE001_E002_E003_E004_E005_E006);
        chk("b2b_second_count", commit_count, 8'd5);
        tick();

        // Reset while PENDING discards the buffered view
        vblank   = 1'b0;
        host_req = 1'b1;
        host_pos = 96'hF00F_F00F_F00F_F00F_F00F_F00F;
        wait_ack(1'b1, 5);
        tick();
        host_req = 1'b0;
        reset    = 1'b1;
        vblank   = 1'b1;
        tick();
        reset = 1'b0;
        s0 = strobes;
        chk("rstp_wnp",    write_new_position, 1'b0);
        chk("rstp_newpos", newpos, '0);
        chk("rstp_busy",   busy, 1'b0);
        chk("rstp_count",  commit_count, '0);
        repeat (5) tick();
        chk("rstp_no_strobe", strobes, s0);

        // Counter wrap over 256 commits
        s0 = strobes;
        for (int i = 0; i < 256; i++) begin
            vblank = 1'b0;
            tick();
            vblank   = 1'b1;
            host_req = 1'b1;
            host_pos = {6{16'(i)}};
            wait_ack(1'b1, 4);
            tick();
            host_req = 1'b0;
            chk("wrap_wnp", write_new_position, 1'b1);
            if (i == 255) chk("wrap_max", {new_playerX, commit_count}, {16'h00FF, 8'd0});
            if (i == 254) chk("wrap_255", commit_count, 8'd255);
            tick();
        end
        chk("wrap_count_zero", commit_count, 8'd0);
        chk("wrap_strobes", strobes, s0 + 256);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
